// File: rtl/jump_engine_pkg.sv
// Shared game definitions: jump FSM encoding and default physics constants.
package jump_engine_pkg;

   typedef enum logic {
      ST_GROUND = 1'b0,
      ST_AIR    = 1'b1
   } jump_state_e;

   // Physics defaults, tuned for a 200 Hz physics tick.
   localparam int DEF_V_JUMP     = 8;
   localparam int DEF_GRAVITY    = 1;
   localparam int DEF_HOLD_TICKS = 3;

   // CLK cycles per physics tick with a 100 MHz CLK.
   localparam int DEF_TICK_DIV   = 500000;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV CLK cycles.
module tick_gen
   import jump_engine_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic CLK,
   input  logic clrn,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == TC);

   // Count 0..TICK_DIV-1 and wrap on the tick cycle.
   always_ff @(posedge CLK or negedge clrn) begin
      if (!clrn) cnt <= '0;
      else if (tick) cnt <= '0;
      else cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/jump_engine.sv
// Dinosaur jump physics: button -> height trajectory with hold-to-extend,
// multi-jump, ceiling clamp, landing pulse and freeze.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_GROUND | resting at height 0, velocity 0, no jumps used
//   ST_AIR    | trajectory in progress, physics advances per tick
module jump_engine
   import jump_engine_pkg::*;
#(
   parameter int H_W        = 6,
   parameter int V_W        = 5,
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int V_JUMP     = DEF_V_JUMP,
   parameter int GRAVITY    = DEF_GRAVITY,
   parameter int HOLD_TICKS = DEF_HOLD_TICKS,
   parameter int MAX_JUMPS  = 2
) (
   input  logic           CLK,
   input  logic           clrn,
   input  logic           btn_jump,
   input  logic           game_status,
   output logic [H_W-1:0] dinosaur_height,
   output logic           airborne,
   output logic [1:0]     jump_count,
   output logic           landed
);

   localparam int HC_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
   localparam logic [HC_W-1:0]       HOLD_LIM = HC_W'(HOLD_TICKS);
   localparam logic [1:0]            MAX_JC   = 2'(MAX_JUMPS);
   localparam logic signed [V_W-1:0] V_LAUNCH = V_W'(V_JUMP);
   localparam logic signed [V_W:0]   V_GRAV   = (V_W + 1)'(GRAVITY);
   localparam logic signed [V_W-1:0] V_FLOOR  = {1'b1, {(V_W - 1){1'b0}}};
   localparam logic signed [H_W+1:0] H_CEIL   = {2'b00, {H_W{1'b1}}};

   logic tick;
   logic btn_s1, btn_s2, btn_s3, btn_rise, req_pend;

   jump_state_e             state_q, state_d;
   logic [H_W-1:0]          h_q, h_d;
   logic signed [V_W-1:0]   v_q, v_d, v_g;
   logic [1:0]              jc_q, jc_d, jc_g;
   logic [HC_W-1:0]         hc_q, hc_d;
   logic                    land_d, land_q;
   logic signed [H_W+1:0]   h_sum;
   logic signed [V_W:0]     v_sub;
   logic                    touch;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLK  (CLK),
      .clrn (clrn),
      .tick (tick)
   );

   assign btn_rise = btn_s2 & ~btn_s3;

   // Synchronise the button and keep the previous level for edge detect.
   always_ff @(posedge CLK or negedge clrn) begin
      if (!clrn) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         btn_s3 <= 1'b0;
      end else begin
         btn_s1 <= btn_jump;
         btn_s2 <= btn_s1;
         btn_s3 <= btn_s2;
      end
   end

   // Latch one jump request per tick window; frozen game drops requests.
   always_ff @(posedge CLK or negedge clrn) begin
      if (!clrn) req_pend <= 1'b0;
      else if (!game_status) req_pend <= 1'b0;
      else if (btn_rise) req_pend <= 1'b1;
      else if (tick) req_pend <= 1'b0;
   end

   // Per-tick physics step: grant, then position, then gravity/hold.
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      jc_d    = jc_q;
      hc_d    = hc_q;
      land_d  = 1'b0;
      v_g     = v_q;
      jc_g    = jc_q;
      h_sum   = '0;
      v_sub   = '0;
      touch   = 1'b0;
      if (tick && game_status) begin
         if (req_pend) begin
            if (state_q == ST_GROUND) begin
               v_g     = V_LAUNCH;
               jc_g    = 2'd1;
               hc_d    = '0;
               state_d = ST_AIR;
            end else if (jc_q < MAX_JC) begin
               v_g  = V_LAUNCH;
               jc_g = jc_q + 2'd1;
               hc_d = '0;
            end
         end
         // V_W is narrower than H_W+2, so sign-extend velocity into the sum.
         h_sum = $signed({2'b00, h_q}) + $signed({{(H_W + 2 - V_W){v_g[V_W-1]}}, v_g});
         touch = (state_d == ST_AIR) &&
                 (h_sum[H_W+1] || (h_sum == '0)) &&
                 (v_g[V_W-1] || (v_g == '0));
         v_d  = v_g;
         jc_d = jc_g;
         if (touch) begin
            h_d     = '0;
            v_d     = '0;
            jc_d    = '0;
            land_d  = 1'b1;
            state_d = ST_GROUND;
         end else if (state_d == ST_AIR) begin
            if (h_sum > H_CEIL) begin
               h_d = {H_W{1'b1}};
               v_d = '0;
            end else begin
               h_d = h_sum[H_W-1:0];
            end
            if (btn_s2 && (hc_d < HOLD_LIM)) begin
               hc_d = hc_d + HC_W'(1);
            end else begin
               v_sub = {v_d[V_W-1], v_d} - V_GRAV;
               v_d   = (v_sub[V_W] != v_sub[V_W-1]) ? V_FLOOR : v_sub[V_W-1:0];
            end
         end
      end
   end

   // Physics and FSM state register.
   always_ff @(posedge CLK or negedge clrn) begin
      if (!clrn) begin
         state_q <= ST_GROUND;
         h_q     <= '0;
         v_q     <= '0;
         jc_q    <= '0;
         hc_q    <= '0;
         land_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
         jc_q    <= jc_d;
         hc_q    <= hc_d;
         land_q  <= land_d;
      end
   end

   assign dinosaur_height = h_q;
   assign jump_count      = jc_q;
   assign landed          = land_q;
   assign airborne        = (state_q == ST_AIR);

endmodule
